// File: rtl/multicycle_ctrl.sv
// Purpose : Moore control FSM for the multicycle datapath (fetch/decode/execute/memory/writeback).
// Latency : R-type/addi 4, lw 5, sw 4, beq/j 3 cycles with memory ready every cycle.
// Backpr. : Stalls in FETCH/MEM_RD/MEM_WR until mem_ready; halts with error after TIMEOUT stalls.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             leaves IDLE (ignored elsewhere)
//   opcode            IR[31:26], held stable from DECODE until the instruction completes
//   mem_ready         memory completed the current access this cycle
//   pc_write .. pc_source   datapath selects and enables
//   state, halted, error    FSM observability; error is sticky until rst
//   instr_count       retired-instruction counter, wraps modulo 2^CNT_W
module multicycle_ctrl #(
    parameter int TIMEOUT = 8,
    parameter int TO_W    = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        st_idle     = 4'd0,
        st_fetch    = 4'd1,
        st_decode   = 4'd2,
        st_mem_addr = 4'd3,
        st_mem_rd   = 4'd4,
        st_wb_mem   = 4'd5,
        st_mem_wr   = 4'd6,
        st_exec_r   = 4'd7,
        st_wb_r     = 4'd8,
        st_branch   = 4'd9,
        st_jump     = 4'd10,
        st_exec_i   = 4'd11,
        st_wb_i     = 4'd12,
        st_halt     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Count value at which one more not-ready cycle exhausts the budget.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit              TO_EN   = (TIMEOUT > 0);

    state_t            cur;
    state_t            nxt;
    logic [TO_W-1:0]   wait_cnt;
    logic [TO_W-1:0]   wait_nxt;
    logic              err_set;
    logic              retire;
    logic              is_wait;
    logic              expire;

    // ------------------------------------------------------------------
    // State, wait counter, sticky error and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= st_idle;
            wait_cnt    <= '0;
            error       <= 1'b0;
            instr_count <= '0;
        end else begin
            cur      <= nxt;
            wait_cnt <= wait_nxt;
            if (err_set) begin
                error <= 1'b1;
            end
            if (retire) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    assign is_wait = (cur == st_fetch) || (cur == st_mem_rd) || (cur == st_mem_wr);

    // Ready takes priority: expiry only matters when this cycle is also not ready.
    assign expire = TO_EN && !mem_ready && (wait_cnt == TO_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        nxt     = cur;
        err_set = 1'b0;
        retire  = 1'b0;

        case (cur)
            st_idle: begin
                if (start) begin
                    nxt = st_fetch;
                end
            end
            st_fetch: begin
                if (mem_ready) begin
                    nxt = st_decode;
                end else if (expire) begin
                    nxt     = st_halt;
                    err_set = 1'b1;
                end
            end
            st_decode: begin
                case (opcode)
                    OP_RTYPE:     nxt = st_exec_r;
                    OP_LW, OP_SW: nxt = st_mem_addr;
                    OP_BEQ:       nxt = st_branch;
                    OP_ADDI:      nxt = st_exec_i;
                    OP_J:         nxt = st_jump;
                    default: begin
                        nxt     = st_halt;
                        err_set = 1'b1;
                    end
                endcase
            end
            st_mem_addr: begin
                nxt = (opcode == OP_LW) ? st_mem_rd : st_mem_wr;
            end
            st_mem_rd: begin
                if (mem_ready) begin
                    nxt = st_wb_mem;
                end else if (expire) begin
                    nxt     = st_halt;
                    err_set = 1'b1;
                end
            end
            st_mem_wr: begin
                if (mem_ready) begin
                    nxt    = st_fetch;
                    retire = 1'b1;
                end else if (expire) begin
                    nxt     = st_halt;
                    err_set = 1'b1;
                end
            end
            st_exec_r: nxt = st_wb_r;
            st_exec_i: nxt = st_wb_i;
            st_wb_mem, st_wb_r, st_wb_i, st_branch, st_jump: begin
                nxt    = st_fetch;
                retire = 1'b1;
            end
            st_halt: nxt = st_halt;
            default: begin
                // Unused encodings 14/15 are treated as a fault.
                nxt     = st_halt;
                err_set = 1'b1;
            end
        endcase
    end

    // Counter runs only while stalled in the same wait state; any ready
    // cycle or state change restarts the budget from zero.
    always_comb begin
        wait_nxt = '0;
        if (is_wait && !mem_ready && (nxt == cur)) begin
            wait_nxt = wait_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs (FETCH additionally gates IR/PC load on mem_ready)
    // ------------------------------------------------------------------
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        halted        = 1'b0;

        case (cur)
            st_fetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            st_decode: begin
                alu_src_b = 2'b11;
            end
            st_mem_addr, st_exec_i: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            st_mem_rd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            st_mem_wr: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            st_wb_mem: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            st_exec_r: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            st_wb_r: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            st_wb_i: begin
                reg_write = 1'b1;
            end
            st_branch: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_source     = 2'b01;
                pc_write_cond = 1'b1;
            end
            st_jump: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
            end
            st_halt: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose : Directed bench for multicycle_ctrl: per-cycle vector table plus corner-case sequences.
// Latency : Inputs driven on negedge, outputs sampled 1 time unit later.
// Backpr. : mem_ready driven directly by the stimulus to create stalls and timeouts.
module tb_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // Control word: pcw pcwc irw mr mw iod rd m2r rw asa asb[2] aop[2] psrc[2] halted
    localparam logic [16:0] C_IDLE    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_FETCH_R = 17'b1_0_1_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FETCH_N = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_MEMADDR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_EXEC_I  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_MEMRD   = 17'b0_0_0_1_0_1_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MEMWR   = 17'b0_0_0_0_1_1_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_WBMEM   = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] C_EXEC_R  = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] C_WBR     = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] C_WBI     = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] C_BRANCH  = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] C_JUMP    = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] C_HALT    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

    typedef struct {
        logic        s;
        logic [5:0]  op;
        logic        r;
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic        err;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (default parameters)
    logic        rst, start, mem_ready;
    logic [5:0]  opcode;
    logic        pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a, halted, error;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [15:0] instr_count;
    logic [16:0] obs;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source), .state(state),
        .halted(halted), .error(error), .instr_count(instr_count)
    );

    assign obs = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, halted};

    // Narrow-counter instance with the timeout disabled
    logic        rst2, start2, rdy2;
    logic [5:0]  op2;
    logic        w_pcw, w_pcwc, w_irw, w_mr, w_mw, w_iod, w_rd, w_m2r, w_rw, w_asa, w_halt, w_err;
    logic [1:0]  w_asb, w_aop, w_psrc, w_cnt;
    logic [3:0]  w_state;

    multicycle_ctrl #(.TIMEOUT(0), .TO_W(4), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst2), .start(start2), .opcode(op2), .mem_ready(rdy2),
        .pc_write(w_pcw), .pc_write_cond(w_pcwc), .ir_write(w_irw),
        .mem_read(w_mr), .mem_write(w_mw), .i_or_d(w_iod), .reg_dst(w_rd),
        .mem_to_reg(w_m2r), .reg_write(w_rw), .alu_src_a(w_asa),
        .alu_src_b(w_asb), .alu_op(w_aop), .pc_source(w_psrc), .state(w_state),
        .halted(w_halt), .error(w_err), .instr_count(w_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic [5:0] op, input logic r, input logic [3:0] st,
                       input logic [16:0] ctrl, input logic err, input logic [15:0] cnt);
        vec_t v;
        v.s = s; v.op = op; v.r = r; v.st = st; v.ctrl = ctrl; v.err = err; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; mem_ready = 1'b1; opcode = OP_R;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_ready = 1'b1; opcode = OP_R;
        rst2 = 1'b1; start2 = 1'b0; rdy2 = 1'b0; op2 = OP_J;

        // ---- per-cycle table: R, lw (3 stalls), sw (1 stall), beq, j, addi, illegal
        add(1, OP_R,    1,  0, C_IDLE,    0, 0);
        add(0, OP_R,    1,  1, C_FETCH_R, 0, 0);
        add(0, OP_R,    1,  2, C_DECODE,  0, 0);
        add(0, OP_R,    1,  7, C_EXEC_R,  0, 0);
        add(0, OP_R,    1,  8, C_WBR,     0, 0);
        add(0, OP_LW,   1,  1, C_FETCH_R, 0, 1);
        add(0, OP_LW,   1,  2, C_DECODE,  0, 1);
        add(0, OP_LW,   1,  3, C_MEMADDR, 0, 1);
        add(0, OP_LW,   0,  4, C_MEMRD,   0, 1);
        add(0, OP_LW,   0,  4, C_MEMRD,   0, 1);
        add(0, OP_LW,   0,  4, C_MEMRD,   0, 1);
        add(0, OP_LW,   1,  4, C_MEMRD,   0, 1);
        add(0, OP_LW,   1,  5, C_WBMEM,   0, 1);
        add(0, OP_SW,   1,  1, C_FETCH_R, 0, 2);
        add(0, OP_SW,   1,  2, C_DECODE,  0, 2);
        add(0, OP_SW,   1,  3, C_MEMADDR, 0, 2);
        add(0, OP_SW,   0,  6, C_MEMWR,   0, 2);
        add(0, OP_SW,   1,  6, C_MEMWR,   0, 2);
        add(0, OP_BEQ,  0,  1, C_FETCH_N, 0, 3);
        add(0, OP_BEQ,  1,  1, C_FETCH_R, 0, 3);
        add(0, OP_BEQ,  1,  2, C_DECODE,  0, 3);
        add(0, OP_BEQ,  1,  9, C_BRANCH,  0, 3);
        add(0, OP_J,    1,  1, C_FETCH_R, 0, 4);
        add(0, OP_J,    1,  2, C_DECODE,  0, 4);
        add(0, OP_J,    1, 10, C_JUMP,    0, 4);
        add(0, OP_ADDI, 1,  1, C_FETCH_R, 0, 5);
        add(0, OP_ADDI, 1,  2, C_DECODE,  0, 5);
        add(0, OP_ADDI, 1, 11, C_EXEC_I,  0, 5);
        add(0, OP_ADDI, 1, 12, C_WBI,     0, 5);
        add(0, OP_BAD,  1,  1, C_FETCH_R, 0, 6);
        add(0, OP_BAD,  1,  2, C_DECODE,  0, 6);
        add(1, OP_BAD,  1, 13, C_HALT,    1, 6);
        add(0, OP_BAD,  1, 13, C_HALT,    1, 6);

        // ---- reset state
        @(negedge clk);
        #1;
        chk("rst_state", 0, 32'(state), 32'd0);
        chk("rst_ctrl",  0, 32'(obs), 32'(C_IDLE));
        chk("rst_err",   0, 32'(error), 32'd0);
        chk("rst_cnt",   0, 32'(instr_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---- table
        for (int i = 0; i < vq.size(); i++) begin
            start = vq[i].s; opcode = vq[i].op; mem_ready = vq[i].r;
            #1;
            chk("vec_state", i, 32'(state), 32'(vq[i].st));
            chk("vec_ctrl",  i, 32'(obs), 32'(vq[i].ctrl));
            chk("vec_err",   i, 32'(error), 32'(vq[i].err));
            chk("vec_cnt",   i, 32'(instr_count), 32'(vq[i].cnt));
            @(negedge clk);
        end

        // ---- HALT is terminal, start pulsed
        for (int k = 0; k < 20; k++) begin
            start = k[0];
            #1;
            chk("halt_hold", k, 32'(state), 32'd13);
            chk("halt_flag", k, 32'(halted), 32'd1);
            @(negedge clk);
        end
        start = 1'b0;

        // ---- timeout in FETCH: 8 not-ready cycles then HALT
        do_reset();
        start = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("to_fetch", k, 32'(state), 32'd1);
            @(negedge clk);
        end
        #1;
        chk("to_halt", 0, 32'(state), 32'd13);
        chk("to_err",  0, 32'(error), 32'd1);

        // ---- ready on the 8th cycle wins
        do_reset();
        start = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mem_ready = (k == 7);
            #1;
            chk("rdy8_fetch", k, 32'(state), 32'd1);
            @(negedge clk);
        end
        #1;
        chk("rdy8_state", 0, 32'(state), 32'd2);
        chk("rdy8_err",   0, 32'(error), 32'd0);

        // ---- asynchronous reset in MEM_WR after one retired instruction
        do_reset();
        start = 1'b1; mem_ready = 1'b1; opcode = OP_R;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("ar_cnt1",  0, 32'(instr_count), 32'd1);
        opcode = OP_SW;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("ar_memwr", 0, 32'(obs), 32'(C_MEMWR));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_state", 0, 32'(state), 32'd0);
        chk("ar_ctrl",  0, 32'(obs), 32'(C_IDLE));
        chk("ar_cnt",   0, 32'(instr_count), 32'd0);
        @(negedge clk);
        #1;
        chk("ar_hold",  0, 32'(state), 32'd0);
        rst = 1'b0;

        // ---- narrow counter wrap, timeout disabled
        @(negedge clk);
        rst2 = 1'b0; start2 = 1'b1; rdy2 = 1'b0; op2 = OP_J;
        @(negedge clk);
        start2 = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("nto_state", 0, 32'(w_state), 32'd1);
        chk("nto_err",   0, 32'(w_err), 32'd0);
        rdy2 = 1'b1;
        repeat (9) @(negedge clk);
        #1;
        chk("wrap_cnt3",  0, 32'(w_cnt), 32'd3);
        chk("wrap_state", 0, 32'(w_state), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("wrap_cnt0",  0, 32'(w_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
